// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the write-back arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_W        = 5;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_MEM  = 2'd3
    } src_e;

    // Only long-latency results retire a scoreboard reservation.
    function automatic logic is_mem_src(input src_e src);
        return (src == SRC_BUF) || (src == SRC_MEM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Power-of-two FIFO holding long-latency results awaiting the port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int               c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_full);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-back arbiter (ALU > buffer > direct mem),
//               with optional pending-write scoreboard (WB_SCOREBOARD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [REG_W-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             mem_valid,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    output logic             mem_ready,
    input  logic             iss_valid,
    input  logic [REG_W-1:0] iss_rd,
    input  logic [REG_W-1:0] q_rs1,
    input  logic [REG_W-1:0] q_rs2,
    output logic             hazard,
    output logic [REG_W-1:0] rd,
    output logic [XLEN-1:0]  writedata,
    output logic             regwrite,
    output logic             ovf
);
    localparam int            c_aw    = $clog2(DEPTH);
    localparam int            c_ew    = REG_W + XLEN;
    localparam logic [c_aw:0] c_depth = DEPTH[c_aw:0];

    logic [c_ew-1:0]  w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [c_aw:0]    w_fifo_count;
    logic [REG_W-1:0] w_buf_rd;
    logic [XLEN-1:0]  w_buf_data;
    src_e             w_sel;
    logic [REG_W-1:0] w_sel_rd;
    logic [XLEN-1:0]  w_sel_data;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_ok;

    logic [REG_W-1:0] r_rd;
    logic [XLEN-1:0]  r_writedata;
    logic             r_regwrite;
    logic             r_ovf;

    wb_fifo #(
        .WIDTH (c_ew),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({mem_rd, mem_data}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign {w_buf_rd, w_buf_data} = w_fifo_dout;
    assign mem_ready = (w_fifo_count < c_depth);

    always_comb begin
        w_sel      = SRC_NONE;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (alu_valid) begin
            w_sel      = SRC_ALU;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end else if (!w_fifo_empty) begin
            w_sel      = SRC_BUF;
            w_sel_rd   = w_buf_rd;
            w_sel_data = w_buf_data;
        end else if (mem_valid) begin
            w_sel      = SRC_MEM;
            w_sel_rd   = mem_rd;
            w_sel_data = mem_data;
        end
    end

    // A full buffer refuses the push even when it is popped on the same edge.
    assign w_pop  = (w_sel == SRC_BUF);
    assign w_push = mem_valid && (w_sel != SRC_MEM) && mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd        <= '0;
            r_writedata <= '0;
            r_regwrite  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_sel != SRC_NONE) begin
                r_rd        <= w_sel_rd;
                r_writedata <= w_sel_data;
                r_regwrite  <= (w_sel_rd != '0);
            end else begin
                r_regwrite  <= 1'b0;
            end
            if (mem_valid && !mem_ready && (w_sel != SRC_MEM)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign rd        = r_rd;
    assign writedata = r_writedata;
    assign regwrite  = r_regwrite;
    assign ovf       = r_ovf;

`ifdef WB_SCOREBOARD_EN
    logic [(1<<REG_W)-1:0] r_pending;
    logic [(1<<REG_W)-1:0] w_pending_nxt;

    // Clear first, then set, so a same-cycle reservation survives the retire.
    always_comb begin
        w_pending_nxt = r_pending;
        if (is_mem_src(w_sel)) begin
            w_pending_nxt[w_sel_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            w_pending_nxt[iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign hazard      = r_pending[q_rs1] | r_pending[q_rs2];
    assign w_unused_ok = w_fifo_full;
`else
    assign hazard      = 1'b0;
    assign w_unused_ok = ^{w_fifo_full, iss_valid, iss_rd, q_rs1, q_rs2};
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter (XLEN=32, DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
    localparam logic c_sb = 1'b1;
`else
    localparam logic c_sb = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        hazard;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic        regwrite;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter #(.XLEN(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .hazard    (hazard),
        .rd        (rd),
        .writedata (writedata),
        .regwrite  (regwrite),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = r; alu_data = d;
    endtask

    task automatic mem(input logic [4:0] r, input logic [31:0] d);
        mem_valid = 1'b1; mem_rd = r; mem_data = d;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite got %0b exp 0", regwrite); end
        n_tests++; if (rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got %0d exp 0", rd); end
        n_tests++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", writedata); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mem_ready got %0b exp 1", mem_ready); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %0b exp 0", ovf); end
        rst = 1'b0;
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL rst_first_cycle got %0b exp 0", regwrite); end
    endtask

    task automatic test_alu_only();
        alu(5'd5, 32'hA5A5_0001);
        cyc(); idle();
        n_tests++; if (regwrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite got %0b exp 1", regwrite); end
        n_tests++; if (rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0d exp 5", rd); end
        n_tests++; if (writedata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL alu_wdata got %h exp a5a50001", writedata); end
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL idle_regwrite got %0b exp 0", regwrite); end
        n_tests++; if (rd !== 5'd5 || writedata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL idle_hold got rd=%0d wd=%h exp rd=5 wd=a5a50001", rd, writedata); end
    endtask

    task automatic test_alu_mem_same();
        alu(5'd3, 32'h33); mem(5'd7, 32'h77);
        cyc(); idle();
        n_tests++; if (regwrite !== 1'b1 || rd !== 5'd3 || writedata !== 32'h33) begin n_fail++; $display("FAIL same_t1 got we=%0b rd=%0d wd=%h exp we=1 rd=3 wd=33", regwrite, rd, writedata); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready got %0b exp 1", mem_ready); end
        cyc();
        n_tests++; if (regwrite !== 1'b1 || rd !== 5'd7 || writedata !== 32'h77) begin n_fail++; $display("FAIL same_t2 got we=%0b rd=%0d wd=%h exp we=1 rd=7 wd=77", regwrite, rd, writedata); end
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL same_t3 got we=%0b exp 0", regwrite); end
    endtask

    task automatic test_overflow();
        alu(5'd1, 32'h1); mem(5'd8, 32'h88);
        cyc();
        n_tests++; if (rd !== 5'd1 || regwrite !== 1'b1) begin n_fail++; $display("FAIL ovf_c0 got rd=%0d we=%0b exp rd=1 we=1", rd, regwrite); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready1 got %0b exp 1", mem_ready); end
        alu(5'd2, 32'h2); mem(5'd9, 32'h99);
        cyc();
        n_tests++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full got %0b exp 0", mem_ready); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b exp 0", ovf); end
        alu(5'd3, 32'h3); mem(5'd10, 32'hAA);
        cyc();
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b exp 1", ovf); end
        n_tests++; if (rd !== 5'd3) begin n_fail++; $display("FAIL ovf_c2_rd got %0d exp 3", rd); end
        mem_valid = 1'b0; alu(5'd4, 32'h4);
        cyc(); idle();
        n_tests++; if (rd !== 5'd4 || regwrite !== 1'b1) begin n_fail++; $display("FAIL ovf_c3 got rd=%0d we=%0b exp rd=4 we=1", rd, regwrite); end
        cyc();
        n_tests++; if (rd !== 5'd8 || writedata !== 32'h88 || regwrite !== 1'b1) begin n_fail++; $display("FAIL ovf_drain8 got rd=%0d wd=%h we=%0b exp rd=8 wd=88 we=1", rd, writedata, regwrite); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_again got %0b exp 1", mem_ready); end
        cyc();
        n_tests++; if (rd !== 5'd9 || writedata !== 32'h99 || regwrite !== 1'b1) begin n_fail++; $display("FAIL ovf_drain9 got rd=%0d wd=%h we=%0b exp rd=9 wd=99 we=1", rd, writedata, regwrite); end
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL ovf_no10 got we=%0b rd=%0d exp we=0", regwrite, rd); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b exp 1", ovf); end
    endtask

    task automatic test_rd_zero();
        mem(5'd0, 32'hDEAD);
        cyc(); idle();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL rd0_direct got we=%0b exp 0", regwrite); end
        alu(5'd6, 32'h66); mem(5'd0, 32'hBEEF);
        cyc(); idle();
        n_tests++; if (regwrite !== 1'b1 || rd !== 5'd6) begin n_fail++; $display("FAIL rd0_alu got we=%0b rd=%0d exp we=1 rd=6", regwrite, rd); end
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL rd0_buf got we=%0b exp 0", regwrite); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_slot_freed got %0b exp 1", mem_ready); end
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL rd0_after got we=%0b exp 0", regwrite); end
    endtask

    task automatic test_scoreboard();
        q_rs1 = 5'd12; q_rs2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd12;
        cyc(); idle();
        n_tests++; if (hazard !== c_sb) begin n_fail++; $display("FAIL sb_c1 got %0b exp %0b", hazard, c_sb); end
        cyc();
        n_tests++; if (hazard !== c_sb) begin n_fail++; $display("FAIL sb_c2 got %0b exp %0b", hazard, c_sb); end
        alu(5'd12, 32'hC0);
        cyc(); idle();
        n_tests++; if (hazard !== c_sb) begin n_fail++; $display("FAIL sb_alu_noclear got %0b exp %0b", hazard, c_sb); end
        q_rs1 = 5'd0; q_rs2 = 5'd12;
        #1;
        n_tests++; if (hazard !== c_sb) begin n_fail++; $display("FAIL sb_rs2 got %0b exp %0b", hazard, c_sb); end
        mem(5'd12, 32'hC);
        cyc(); idle();
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_cleared got %0b exp 0", hazard); end
        n_tests++; if (regwrite !== 1'b1 || rd !== 5'd12 || writedata !== 32'hC) begin n_fail++; $display("FAIL sb_write got we=%0b rd=%0d wd=%h exp we=1 rd=12 wd=c", regwrite, rd, writedata); end
        // Reservation and retirement of r12 on the same edge.
        iss_valid = 1'b1; iss_rd = 5'd12;
        cyc();
        mem(5'd12, 32'hD);
        cyc(); idle();
        n_tests++; if (hazard !== c_sb) begin n_fail++; $display("FAIL sb_set_wins got %0b exp %0b", hazard, c_sb); end
        mem(5'd12, 32'hE);
        cyc(); idle();
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_final_clear got %0b exp 0", hazard); end
        q_rs2 = 5'd0;
    endtask

    task automatic test_reset_mid();
        q_rs1 = 5'd4;
        iss_valid = 1'b1; iss_rd = 5'd4; alu(5'd1, 32'h11); mem(5'd20, 32'h20);
        cyc();
        iss_valid = 1'b0; alu(5'd2, 32'h22); mem(5'd21, 32'h21);
        cyc(); idle();
        n_tests++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got %0b exp 0", mem_ready); end
        n_tests++; if (hazard !== c_sb) begin n_fail++; $display("FAIL mid_pending got %0b exp %0b", hazard, c_sb); end
        rst = 1'b1;
        #1;
        n_tests++; if (regwrite !== 1'b0 || rd !== 5'd0 || writedata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_port got we=%0b rd=%0d wd=%h exp all 0", regwrite, rd, writedata); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %0b exp 1", mem_ready); end
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hazard got %0b exp 0", hazard); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %0b exp 0", ovf); end
        cyc();
        rst = 1'b0;
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL mid_after1 got %0b exp 0", regwrite); end
        cyc();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL mid_after2 got %0b exp 0", regwrite); end
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mid_after_hazard got %0b exp 0", hazard); end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_alu_mem_same();
        test_overflow();
        test_rd_zero();
        test_scoreboard();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, data width of results and write port.
REQ-002 Parameter: DEPTH, default 2, long-latency result buffer entries (power of 2, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 alu_valid/alu_rd/alu_data  input  1/5/XLEN  single-cycle result; always accepted.
REQ-006 mem_valid/mem_rd/mem_data  input  1/5/XLEN  long-latency (load/mul) result.
REQ-007 mem_ready  output  1  buffer can accept a mem result this cycle.
REQ-008 iss_valid/iss_rd  input  1/5  issue of a long-latency op, reserves iss_rd.
REQ-009 q_rs1/q_rs2  input  5/5  decode-stage source registers to check.
REQ-010 hazard  output  1  a queried source has a pending long-latency write.
REQ-011 rd/writedata/regwrite  output  5/XLEN/1  register-file write port, registered.
REQ-012 ovf  output  1  sticky: mem result dropped while mem_ready=0.

Function
REQ-013 At most one register-file write per cycle; inputs reach write port exactly 1 cycle after selection.
REQ-014 Selection priority per cycle: alu_valid, else buffer head, else mem_valid direct (bypassing buffer).
REQ-015 mem result not selected directly and mem_ready=1 -> pushed to buffer same edge.
REQ-016 mem_ready = (buffer count < DEPTH), combinational from registered count only.
REQ-017 Push and pop in same cycle when full: pop occurs, push refused (mem_ready was 0), ovf set.
REQ-018 Buffer order strictly FIFO; pointers wrap modulo DEPTH.
REQ-019 Selected entry with rd=0: consumes the slot, regwrite=0, writedata don't-care.
REQ-020 No selection: regwrite=0 next cycle, rd/writedata hold previous values.
REQ-021 Scoreboard pending[31:1]: iss_valid with iss_rd!=0 sets pending[iss_rd].
REQ-022 pending[r] cleared on the edge a mem-sourced write of r is selected; ALU writes never clear.
REQ-023 Set and clear of same r in same cycle: set wins.
REQ-024 hazard = pending[q_rs1] | pending[q_rs2], combinational; index 0 always reads 0.
REQ-025 ovf set when mem_valid=1 and mem_ready=0 and mem not selected directly; cleared only by rst.

Reset
REQ-026 rst asserted (any time, mid-operation): regwrite=0, rd=0, writedata=0, buffer empty, count=0, pending all 0, ovf=0, immediately.
REQ-027 Buffered results at reset are discarded; no write issues in the first cycle after deassertion.

Configuration
REQ-028 Macro WB_SCOREBOARD_EN defined: REQ-021..024 implemented.
REQ-029 WB_SCOREBOARD_EN undefined: no pending register, hazard tied 0, iss_* and q_* ignored.

Structure
REQ-030 Shared package wb_pkg: XLEN default, REG_W=5, source enum {SRC_NONE, SRC_ALU, SRC_BUF, SRC_MEM}.
REQ-031 Buffer implemented as sub-module wb_fifo (push/pop/full/empty/count, async reset).
REQ-032 Arbiter, scoreboard, output register in wb_arbiter top.

Verification
REQ-033 alu_valid rd=5 data=0xA5A5_0001 alone -> next cycle regwrite=1, rd=5, writedata=0xA5A5_0001.
REQ-034 alu rd=3 and mem rd=7 (0x77) same cycle -> write rd=3 cycle t+1, rd=7 data=0x77 cycle t+2.
REQ-035 ALU busy 4 cycles, mem results rd=8,9,10 on cycles 0,1,2 (DEPTH=2) -> rd=8,9 buffered, mem_ready=0 at cycle 2, ovf=1, rd=10 never written.
REQ-036 iss rd=12 cycle 0, q_rs1=12 -> hazard=1 cycles 1..; mem rd=12 selected cycle 4 -> hazard=0 cycle 5.
REQ-037 iss rd=12 and mem write rd=12 selected same cycle -> pending[12] stays 1; mem rd=0 -> regwrite stays 0.
REQ-038 rst pulsed with 2 buffered entries and pending[4]=1 -> regwrite=0, mem_ready=1, hazard=0, no write after release.
